// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment loop-back monitor.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int NUM_DIGITS = 4;

    localparam int ERR_SEG   = 0;
    localparam int ERR_AN    = 1;
    localparam int ERR_RANGE = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to BCD decoder.
// Blank decodes to 0; unknown patterns report !ok_o and digit 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       ok_o,
    output logic [3:0] digit_o
);

    always_comb begin
        ok_o    = 1'b1;
        digit_o = 4'd0;
        case (pattern_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: digit_o = 4'd0;
            default:   ok_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Loop-back monitor for the multiplexed 4-digit display bus: debounces each
// digit dwell, decodes it, and publishes the reassembled value per full scan.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [7:0]  value,
    output logic [15:0] digits,
    output logic        valid,
    output logic        frame_done,
    output logic [2:0]  err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic [10:0]   sample;
    logic [10:0]   prev_q;
    logic [7:0]    stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    state_t        state_q, state_d;
    logic [3:0]    dreg_q [NUM_DIGITS];
    logic [3:0]    mask_q, mask_d;
    logic [1:0]    acc_q, acc_d;

    logic [7:0]    value_q;
    logic [15:0]   digits_q;
    logic          valid_q, frame_done_q;
    logic [2:0]    err_q;

    logic          capture_w, cap_event, cap_digit, cap_conflict, cap_bad_seg;
    logic [3:0]    cap_an, cap_onehot;
    logic [6:0]    cap_seg;
    logic [2:0]    zero_cnt;
    logic [1:0]    zero_idx;
    logic          seg_ok;
    logic [3:0]    seg_digit;
    logic          publish_w, abort_w, range_w;
    logic [9:0]    sum_w;
    logic [2:0]    err_pub;

    logic unused_dp;
    assign unused_dp = dp;

    // Idle bus values on reset so the debouncer never captures a phantom dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= SEG_BLANK;
            an_q   <= 4'hF;
            prev_q <= {4'hF, SEG_BLANK};
            stab_q <= 8'd0;
        end else begin
            seg_q  <= seg;
            an_q   <= an;
            prev_q <= sample;
            stab_q <= stab_d;
        end
    end

    assign sample = {an_q, seg_q};

    always_comb begin
        if (sample != prev_q)
            stab_d = 8'd0;
        else if (stab_q == 8'(SETTLE))
            stab_d = stab_q;
        else
            stab_d = stab_q + 8'd1;
    end

    // prev_q holds the settled pattern whenever the count sits at SETTLE-1.
    assign capture_w = (stab_q == 8'(SETTLE - 1));
    assign cap_an    = prev_q[10:7];
    assign cap_seg   = prev_q[6:0];

    always_comb begin
        zero_cnt = 3'd0;
        zero_idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!cap_an[i]) begin
                zero_cnt = zero_cnt + 3'd1;
                zero_idx = 2'(i);
            end
        end
    end

    seg7_pattern_decode u_decode (
        .pattern_i (cap_seg),
        .ok_o      (seg_ok),
        .digit_o   (seg_digit)
    );

    assign cap_event    = capture_w && (zero_cnt != 3'd0);
    assign cap_digit    = capture_w && (zero_cnt == 3'd1);
    assign cap_conflict = capture_w && (zero_cnt > 3'd1);
    assign cap_bad_seg  = cap_digit && !seg_ok;
    assign cap_onehot   = cap_digit ? (4'b0001 << zero_idx) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_event) state_d = COLLECT;
            COLLECT: begin
                if (cap_event && (mask_d == 4'hF))
                    state_d = PUBLISH;
                else if (abort_w)
                    state_d = IDLE;
            end
            PUBLISH: state_d = cap_event ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        publish_w = 1'b0;
        abort_w   = 1'b0;
        case (state_q)
            PUBLISH: publish_w = 1'b1;
            COLLECT: abort_w   = !cap_event && (tmo_q == TW'(TIMEOUT - 1));
            default: ;
        endcase
    end

    // A capture in the publish cycle starts the next frame from a clean mask.
    always_comb begin
        mask_d = ((publish_w || abort_w) ? 4'b0000 : mask_q) | cap_onehot;
        acc_d  = ((publish_w || abort_w) ? 2'b00 : acc_q) | {cap_conflict, cap_bad_seg};
        tmo_d  = (cap_event || state_q != COLLECT) ? '0 : tmo_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 4'b0000;
            acc_q  <= 2'b00;
            tmo_q  <= '0;
        end else begin
            mask_q <= mask_d;
            acc_q  <= acc_d;
            tmo_q  <= tmo_d;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dreg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                dreg_q[gi] <= 4'd0;
            else if (cap_onehot[gi])
                dreg_q[gi] <= seg_digit;
        end
    end

    assign sum_w   = {6'd0, dreg_q[2]} * 10'd100 + {6'd0, dreg_q[1]} * 10'd10 + {6'd0, dreg_q[0]};
    assign range_w = (dreg_q[3] != 4'd0) || (sum_w > 10'd255);
    always_comb begin
        err_pub            = {1'b0, acc_q};
        err_pub[ERR_RANGE] = range_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q      <= 8'd0;
            digits_q     <= 16'd0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 3'd0;
        end else begin
            frame_done_q <= publish_w;
            if (publish_w) begin
                err_q    <= err_pub;
                digits_q <= {dreg_q[3], dreg_q[2], dreg_q[1], dreg_q[0]};
                if (err_pub == 3'd0) begin
                    value_q <= sum_w[7:0];
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign value      = value_q;
    assign digits     = digits_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scans,
// scored against a dwell-level model of the capture/publish rules.
module tb_seg7_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic        dp = 1'b0;
    logic [7:0]  value;
    logic [15:0] digits;
    logic        valid;
    logic        frame_done;
    logic [2:0]  err;

    seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .value      (value),
        .digits     (digits),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int obs_frames = 0;

    always @(negedge clk) if (rst_n && frame_done === 1'b1) obs_frames++;

    logic [6:0] pat_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] bad_tab [0:3] = '{7'h2A, 7'h55, 7'h7E, 7'h3F};

    // Model state: one abstract frame under assembly plus the expected outputs.
    int          m_dig [4];
    bit [3:0]    m_mask;
    bit [1:0]    m_acc;
    bit          m_active;
    longint      m_last_cap;
    longint      cyc = 0;
    int          e_frames = 0;
    logic [7:0]  e_value;
    logic [15:0] e_digits;
    logic        e_valid;
    logic [2:0]  e_err;
    logic [10:0] prev_drv = {4'hF, 7'h7F};

    task automatic model_clear_all();
        m_active = 0; m_mask = 0; m_acc = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        e_value = 0; e_digits = 0; e_valid = 0; e_err = 0;
    endtask

    task automatic model_dwell(input logic [3:0] a, input logic [6:0] s, input int len);
        int zeros, k, d, sum;
        bit ok, rng;
        longint t;
        if (len < SETTLE || a == 4'hF) return;
        t = cyc + SETTLE;
        if (m_active && (t - m_last_cap) > TIMEOUT) begin
            m_active = 0; m_mask = 0; m_acc = 0;
        end
        m_active = 1;
        m_last_cap = t;
        zeros = 0; k = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; k = i; end
        if (zeros > 1) begin
            m_acc[1] = 1'b1;
        end else begin
            ok = (s == 7'h7F); d = 0;
            for (int j = 0; j < 10; j++) if (pat_tab[j] == s) begin ok = 1; d = j; end
            if (!ok) m_acc[0] = 1'b1;
            m_dig[k] = d;
            m_mask[k] = 1'b1;
        end
        if (m_mask == 4'hF) begin
            sum = m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
            rng = (m_dig[3] != 0) || (sum > 255);
            e_frames++;
            e_err = {rng, m_acc};
            e_digits = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
            if (e_err == 3'd0) begin
                e_value = 8'(sum);
                e_valid = 1'b1;
            end else begin
                e_valid = 1'b0;
            end
            m_active = 0; m_mask = 0; m_acc = 0;
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
        if ({a, s} == prev_drv && a != 4'hF) begin
            an = 4'hF; seg = 7'h7F;
            @(negedge clk); cyc++;
        end
        model_dwell(a, s, len);
        an = a; seg = s;
        repeat (len) begin @(negedge clk); cyc++; end
        prev_drv = {a, s};
    endtask

    task automatic digit(input int k, input int d, input int len);
        logic [3:0] a;
        a = ~(4'b0001 << k);
        dwell(a, pat_tab[d], len);
    endtask

    task automatic flush();
        dwell(4'hF, 7'h7F, 8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
        repeat (3) begin @(negedge clk); cyc++; end
        rst_n = 1'b1;
        model_clear_all();
        prev_drv = {4'hF, 7'h7F};
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (value !== 8'd0)      begin bad++; $display("FAIL reset_value: got %h want 00", value); end
        if (digits !== 16'd0)    begin bad++; $display("FAIL reset_digits: got %h want 0000", digits); end
        if (valid !== 1'b0)      begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        if (err !== 3'd0)        begin bad++; $display("FAIL reset_err: got %b want 000", err); end
        $display("reset: value=%h digits=%h valid=%b err=%b", value, digits, valid, err);
    endtask

    task automatic test_good_frame();
        int f0;
        f0 = obs_frames;
        digit(0, 3, 16); digit(1, 7, 16); digit(2, 1, 16); digit(3, 0, 16);
        flush();
        total += 6;
        if (obs_frames - f0 !== 1) begin bad++; $display("FAIL good_frames: got %0d want 1", obs_frames - f0); end
        if (value !== 8'hAD)       begin bad++; $display("FAIL good_value: got %h want ad", value); end
        if (digits !== 16'h0173)   begin bad++; $display("FAIL good_digits: got %h want 0173", digits); end
        if (valid !== 1'b1)        begin bad++; $display("FAIL good_valid: got %b want 1", valid); end
        if (err !== 3'b000)        begin bad++; $display("FAIL good_err: got %b want 000", err); end
        if ({value, digits, valid, err} !== {e_value, e_digits, e_valid, e_err}) begin
            bad++; $display("FAIL good_model: got %h want %h", {value, digits, valid, err}, {e_value, e_digits, e_valid, e_err});
        end
        $display("good frame: value=%h digits=%h valid=%b err=%b", value, digits, valid, err);
    endtask

    task automatic test_bad_segment();
        digit(0, 5, 16); dwell(4'b1101, 7'b0101010, 16); digit(2, 0, 16); digit(3, 0, 16);
        flush();
        total += 4;
        if (err !== 3'b001)  begin bad++; $display("FAIL badseg_err: got %b want 001", err); end
        if (valid !== 1'b0)  begin bad++; $display("FAIL badseg_valid: got %b want 0", valid); end
        if (value !== 8'hAD) begin bad++; $display("FAIL badseg_value: got %h want ad", value); end
        if ({value, digits, valid, err} !== {e_value, e_digits, e_valid, e_err}) begin
            bad++; $display("FAIL badseg_model: got %h want %h", {value, digits, valid, err}, {e_value, e_digits, e_valid, e_err});
        end
        $display("bad segment: value=%h digits=%h valid=%b err=%b", value, digits, valid, err);
    endtask

    task automatic test_anode_conflict();
        digit(0, 1, 16); dwell(4'b1100, pat_tab[8], 16); digit(1, 2, 16); digit(2, 0, 16); digit(3, 0, 16);
        flush();
        total += 3;
        if (err[1] !== 1'b1) begin bad++; $display("FAIL conflict_err: got %b want x1x", err); end
        if (valid !== 1'b0)  begin bad++; $display("FAIL conflict_valid: got %b want 0", valid); end
        if ({value, digits, valid, err} !== {e_value, e_digits, e_valid, e_err}) begin
            bad++; $display("FAIL conflict_model: got %h want %h", {value, digits, valid, err}, {e_value, e_digits, e_valid, e_err});
        end
        $display("anode conflict: value=%h digits=%h valid=%b err=%b", value, digits, valid, err);
    endtask

    task automatic test_range();
        digit(0, 6, 16); digit(1, 5, 16); digit(2, 2, 16); digit(3, 0, 16);
        flush();
        total += 2;
        if (err !== 3'b100) begin bad++; $display("FAIL range256_err: got %b want 100", err); end
        if (valid !== 1'b0) begin bad++; $display("FAIL range256_valid: got %b want 0", valid); end
        $display("range 256: value=%h digits=%h valid=%b err=%b", value, digits, valid, err);
        digit(0, 5, 16); digit(1, 5, 16); digit(2, 2, 16); digit(3, 0, 16);
        flush();
        total += 4;
        if (value !== 8'hFF) begin bad++; $display("FAIL range255_value: got %h want ff", value); end
        if (valid !== 1'b1)  begin bad++; $display("FAIL range255_valid: got %b want 1", valid); end
        if (err !== 3'b000)  begin bad++; $display("FAIL range255_err: got %b want 000", err); end
        if ({value, digits, valid, err} !== {e_value, e_digits, e_valid, e_err}) begin
            bad++; $display("FAIL range255_model: got %h want %h", {value, digits, valid, err}, {e_value, e_digits, e_valid, e_err});
        end
        $display("range 255: value=%h digits=%h valid=%b err=%b", value, digits, valid, err);
    endtask

    task automatic test_glitch_dwell();
        int f0;
        f0 = obs_frames;
        digit(0, 8, 16); digit(1, 4, 16); digit(2, 0, 16);
        digit(3, 0, 2); flush();
        total++;
        if (obs_frames - f0 !== 0) begin bad++; $display("FAIL glitch2_frames: got %0d want 0", obs_frames - f0); end
        digit(3, 0, SETTLE - 1); flush();
        total++;
        if (obs_frames - f0 !== 0) begin bad++; $display("FAIL glitch3_frames: got %0d want 0", obs_frames - f0); end
        digit(3, 0, SETTLE); flush();
        total += 2;
        if (obs_frames - f0 !== 1) begin bad++; $display("FAIL settle_frames: got %0d want 1", obs_frames - f0); end
        if (value !== 8'd48)       begin bad++; $display("FAIL settle_value: got %h want 30", value); end
        $display("glitch: frames=%0d value=%h", obs_frames - f0, value);
        // A long dwell must capture once: a second capture would seed the next frame.
        f0 = obs_frames;
        digit(1, 1, 16); digit(2, 1, 16); digit(3, 0, 16); digit(0, 9, 100); flush();
        digit(1, 2, 16); digit(2, 0, 16); digit(3, 0, 16); flush();
        total += 2;
        if (obs_frames - f0 !== 1) begin bad++; $display("FAIL longdwell_frames: got %0d want 1", obs_frames - f0); end
        if (value !== 8'd119)      begin bad++; $display("FAIL longdwell_value: got %h want 77", value); end
        $display("long dwell: frames=%0d value=%h", obs_frames - f0, value);
    endtask

    task automatic test_timeout();
        int f0;
        dwell(4'hF, 7'h7F, TIMEOUT + 16);
        f0 = obs_frames;
        digit(0, 2, 16); digit(1, 2, 16); digit(2, 1, 16);
        dwell(4'hF, 7'h7F, TIMEOUT + 16);
        digit(3, 0, 16); flush();
        total++;
        if (obs_frames - f0 !== 0) begin bad++; $display("FAIL timeout_frames: got %0d want 0", obs_frames - f0); end
        digit(0, 7, 16); digit(1, 3, 16); digit(2, 0, 16); flush();
        total += 3;
        if (obs_frames - f0 !== 1) begin bad++; $display("FAIL after_timeout_frames: got %0d want 1", obs_frames - f0); end
        if (value !== 8'd37)       begin bad++; $display("FAIL after_timeout_value: got %h want 25", value); end
        if ({value, digits, valid, err} !== {e_value, e_digits, e_valid, e_err}) begin
            bad++; $display("FAIL timeout_model: got %h want %h", {value, digits, valid, err}, {e_value, e_digits, e_valid, e_err});
        end
        $display("timeout: frames=%0d value=%h", obs_frames - f0, value);
    endtask

    task automatic test_reset_mid_frame();
        int f0;
        digit(0, 4, 16); digit(1, 6, 16);
        #3 rst_n = 1'b0;
        #1;
        total += 5;
        if (value !== 8'd0)      begin bad++; $display("FAIL areset_value: got %h want 00", value); end
        if (digits !== 16'd0)    begin bad++; $display("FAIL areset_digits: got %h want 0000", digits); end
        if (valid !== 1'b0)      begin bad++; $display("FAIL areset_valid: got %b want 0", valid); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL areset_frame_done: got %b want 0", frame_done); end
        if (err !== 3'd0)        begin bad++; $display("FAIL areset_err: got %b want 000", err); end
        $display("async reset: value=%h digits=%h valid=%b err=%b", value, digits, valid, err);
        an = 4'hF; seg = 7'h7F;
        @(negedge clk); cyc++;
        do_reset();
        f0 = obs_frames;
        digit(2, 1, 16); digit(3, 0, 16); flush();
        total++;
        if (obs_frames - f0 !== 0) begin bad++; $display("FAIL postreset_partial: got %0d want 0", obs_frames - f0); end
        digit(0, 2, 16); digit(1, 0, 16); flush();
        total += 2;
        if (obs_frames - f0 !== 1) begin bad++; $display("FAIL postreset_frames: got %0d want 1", obs_frames - f0); end
        if (value !== 8'd102)      begin bad++; $display("FAIL postreset_value: got %h want 66", value); end
        $display("post reset frame: value=%h digits=%h", value, digits);
    endtask

    task automatic test_random();
        int f0, ef0, kind, d, len;
        int ord [4];
        for (int it = 0; it < 30; it++) begin
            f0 = obs_frames; ef0 = e_frames;
            for (int i = 0; i < 4; i++) ord[i] = i;
            for (int i = 3; i > 0; i--) begin
                int j, tmp;
                j = $urandom_range(0, i);
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
            for (int p = 0; p < 4; p++) begin
                kind = $urandom_range(0, 19);
                len = $urandom_range(SETTLE, 20);
                if (ord[p] == 3)      d = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : 0;
                else if (ord[p] == 2) d = $urandom_range(0, 2);
                else                  d = $urandom_range(0, 9);
                case (kind)
                    1: dwell(4'(~(4'b0011 << $urandom_range(0, 2))), pat_tab[$urandom_range(0, 9)], $urandom_range(SETTLE, 12));
                    2: digit(ord[p], $urandom_range(0, 9), $urandom_range(1, SETTLE - 1));
                    3: dwell(4'hF, 7'h7F, $urandom_range(5, 15));
                    4: digit(ord[p], $urandom_range(0, 9), $urandom_range(SETTLE, 12));
                    default: ;
                endcase
                if (kind == 0) begin
                    logic [3:0] a;
                    a = ~(4'b0001 << ord[p]);
                    dwell(a, bad_tab[$urandom_range(0, 3)], len);
                end else if (kind != 5) begin
                    digit(ord[p], d, len);
                end
            end
            flush();
            total += 2;
            if (obs_frames - f0 !== e_frames - ef0) begin
                bad++; $display("FAIL rand_frames[%0d]: got %0d want %0d", it, obs_frames - f0, e_frames - ef0);
            end
            if ({value, digits, valid, err} !== {e_value, e_digits, e_valid, e_err}) begin
                bad++; $display("FAIL rand_outputs[%0d]: got %h want %h", it, {value, digits, valid, err}, {e_value, e_digits, e_valid, e_err});
            end
            $display("random %0d: frames=%0d value=%h digits=%h valid=%b err=%b", it, obs_frames - f0, value, digits, valid, err);
        end
    endtask

    initial begin
        model_clear_all();
        test_reset();
        test_good_frame();
        test_bad_segment();
        test_anode_conflict();
        test_range();
        test_glitch_dwell();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
